mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// A multiply or divide takes 33 cycles from capture to done; MTHI/MTLO write in one cycle.
module mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state;
  logic [5:0]  count;
  logic        is_div;
  logic        neg_q;      // sign of product / quotient
  logic        neg_r;      // sign of remainder (dividend sign)
  logic        div_zero;
  logic [31:0] opnd;       // multiplicand or divisor magnitude
  logic [63:0] p;          // {acc/remainder, multiplier/dividend-quotient}

  logic        is_arith;
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed && A[31];
    b_neg     = is_signed && B[31];
    a_mag     = a_neg ? (~A + 32'd1) : A;
    b_mag     = b_neg ? (~B + 32'd1) : B;

    mul_sum   = {1'b0, p[63:32]} + (p[0] ? {1'b0, opnd} : 33'd0);
    // Restoring step: a set borrow bit means the trial subtraction is discarded.
    rem_sh    = {p[63:32], p[31]};
    rem_diff  = rem_sh - {1'b0, opnd};

    prod_fix  = neg_q ? (~p + 64'd1) : p;
    quo_fix   = neg_q ? (~p[31:0] + 32'd1) : p[31:0];
    rem_fix   = neg_r ? (~p[63:32] + 32'd1) : p[63:32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 6'd0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= 32'd0;
      p        <= 64'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_arith) begin
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= op[1] && (B == 32'd0);
            opnd     <= op[1] ? b_mag : a_mag;
            p        <= op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
            count    <= 6'd0;
            busy     <= 1'b1;
            state    <= CALC;
          end else if (start && op == OP_MTHI) begin
            HI <= A;
          end else if (start && op == OP_MTLO) begin
            LO <= A;
          end
        end
        CALC: begin
          if (is_div) begin
            if (rem_diff[32])
              p <= {rem_sh[31:0], p[30:0], 1'b0};
            else
              p <= {rem_diff[31:0], p[30:0], 1'b1};
          end else begin
            p <= {mul_sum, p[31:1]};
          end
          count <= count + 6'd1;
          if (count == 6'd31)
            state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            LO <= div_zero ? 32'hFFFF_FFFF : quo_fix;
            HI <= rem_fix;
          end else begin
            HI <= prod_fix[63:32];
            LO <= prod_fix[31:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
